exec_arbiter: RTL and testbench

EXEC_ARBITER -- requirements
Module: exec_arbiter

---
 rtl/exec_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_exec_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_arbiter.sv
// -----------------------------------------------------------------------------
// exec_arbiter
//
// Two-requester front end for a single shared execution unit. One operation is
// in flight at a time: a requester is granted in IDLE, its operands are
// registered onto the eu_* bus, the unit is given L cycles to settle (L =
// MUL_LAT for M-extension ops, 1 otherwise), the result is captured and then
// held in RESP until the consumer takes it.
//
// Parameters
//   MUL_LAT  EXEC cycles for M-extension ops (auxFunc == 7'b0000001), 1..15
//   CNT_W    width of the per-requester grant counters
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshake per requester
//   req{0,1}_opA/_opB        32-bit operands
//   req{0,1}_func/_auxFunc   funct3 / funct7
//   eu_opA/_opB/_func/_auxFunc  registered operation driven to the unit
//   eu_out                   combinational result from the unit
//   rsp_valid/_ready         response handshake
//   rsp_id                   requester that issued the held result
//   rsp_data                 captured result
//   busy                     high whenever the FSM is not in IDLE
//   grant_cnt0/_cnt1         accepted-operation counters (wrap)
// -----------------------------------------------------------------------------
module exec_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_opA,
    input  logic [31:0]      req0_opB,
    input  logic [2:0]       req0_func,
    input  logic [6:0]       req0_auxFunc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_opA,
    input  logic [31:0]      req1_opB,
    input  logic [2:0]       req1_func,
    input  logic [6:0]       req1_auxFunc,

    output logic [31:0]      eu_opA,
    output logic [31:0]      eu_opB,
    output logic [2:0]       eu_func,
    output logic [6:0]       eu_auxFunc,
    input  logic [31:0]      eu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,

    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [6:0]       AUX_MULDIV = 7'b0000001;
    // Counter is loaded with L-1 so that EXEC lasts exactly L cycles.
    localparam logic [3:0]       MUL_LOAD   = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic [3:0]  cyc_cnt;
    logic        last_grant;

    logic        sel;        // requester chosen by arbitration this cycle
    logic        hs;         // handshake with the selected requester
    logic [31:0] win_opA;
    logic [31:0] win_opB;
    logic [2:0]  win_func;
    logic [6:0]  win_auxFunc;

    function automatic logic [3:0] lat_load(input logic [6:0] aux);
        return (aux == AUX_MULDIV) ? MUL_LOAD : 4'd0;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration: a lone valid wins outright; on contention the requester
    // not recorded in last_grant wins.
    // -------------------------------------------------------------------------
    always_comb begin
        if (req0_valid && req1_valid) begin
            sel = ~last_grant;
        end else begin
            sel = req1_valid;
        end
    end

    always_comb begin
        win_opA     = sel ? req1_opA     : req0_opA;
        win_opB     = sel ? req1_opB     : req0_opB;
        win_func    = sel ? req1_func    : req0_func;
        win_auxFunc = sel ? req1_auxFunc : req0_auxFunc;
    end

    // -------------------------------------------------------------------------
    // Next state and ready outputs. Ready is gated by reset so it drops at
    // once on an asynchronous reset even while a requester holds valid.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~sel & ~reset;
                req1_ready = req1_valid &  sel & ~reset;
                hs         = req0_ready | req1_ready;
                if (hs) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cyc_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Consumed response returns to IDLE; no grant in this cycle.
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and EXEC cycle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && hs) begin
                cyc_cnt <= lat_load(win_auxFunc);
            end else if (state == EXEC && cyc_cnt != 4'd0) begin
                cyc_cnt <= cyc_cnt - 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Operation capture on handshake. The eu_* bus only changes here, so it
    // stays stable through EXEC and RESP until the next grant.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eu_opA     <= 32'd0;
            eu_opB     <= 32'd0;
            eu_func    <= 3'd0;
            eu_auxFunc <= 7'd0;
            last_grant <= 1'b1;    // requester 0 wins the first contention
            rsp_id     <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == IDLE && hs) begin
            eu_opA     <= win_opA;
            eu_opB     <= win_opB;
            eu_func    <= win_func;
            eu_auxFunc <= win_auxFunc;
            last_grant <= sel;
            rsp_id     <= sel;
            if (sel) begin
                grant_cnt1 <= grant_cnt1 + CNT_ONE;
            end else begin
                grant_cnt0 <= grant_cnt0 + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result capture on the last EXEC cycle only
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data <= 32'd0;
        end else if (state == EXEC && cyc_cnt == 4'd0) begin
            rsp_data <= eu_out;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_exec_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exec_arbiter
//
// Directed bench for exec_arbiter with a small behavioural execution unit
// (ADD/SUB/MUL/SLL/SRL/SRA) closing the eu_* -> eu_out loop.
// -----------------------------------------------------------------------------
module tb_exec_arbiter;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_opA, req0_opB, req1_opA, req1_opB;
    logic [2:0]       req0_func, req1_func;
    logic [6:0]       req0_auxFunc, req1_auxFunc;
    logic [31:0]      eu_opA, eu_opB;
    logic [2:0]       eu_func;
    logic [6:0]       eu_auxFunc;
    logic [31:0]      eu_out;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [31:0]      rsp_data;
    logic             busy;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int n_pass  = 0;
    int n_total = 0;

    exec_arbiter #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opA(req0_opA), .req0_opB(req0_opB),
        .req0_func(req0_func), .req0_auxFunc(req0_auxFunc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opA(req1_opA), .req1_opB(req1_opB),
        .req1_func(req1_func), .req1_auxFunc(req1_auxFunc),
        .eu_opA(eu_opA), .eu_opB(eu_opB),
        .eu_func(eu_func), .eu_auxFunc(eu_auxFunc), .eu_out(eu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural execution unit
    always_comb begin
        eu_out = eu_opA ^ eu_opB;
        case (eu_func)
            3'b000: begin
                if (eu_auxFunc == 7'b0000001) eu_out = 32'(eu_opA * eu_opB);
                else if (eu_auxFunc[5])       eu_out = eu_opA - eu_opB;
                else                          eu_out = eu_opA + eu_opB;
            end
            3'b001: eu_out = eu_opA << eu_opB[4:0];
            3'b101: begin
                if (eu_auxFunc[5]) eu_out = 32'($signed(eu_opA) >>> eu_opB[4:0]);
                else               eu_out = eu_opA >> eu_opB[4:0];
            end
            default: eu_out = eu_opA ^ eu_opB;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input logic [6:0] x);
        req0_opA = a; req0_opB = b; req0_func = f; req0_auxFunc = x;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input logic [6:0] x);
        req1_opA = a; req1_opB = b; req1_func = f; req1_auxFunc = x;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        set_req0(32'd0, 32'd0, 3'd0, 7'd0);
        set_req1(32'd0, 32'd0, 3'd0, 7'd0);

        // ---- reset state (valid held high to check ready is suppressed) ----
        tick();
        req0_valid = 1'b1;
        tick();
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_ready0",    32'(req0_ready), 32'd0);
        chk("rst_eu_opA",    eu_opA,          32'd0);
        chk("rst_rsp_data",  rsp_data,        32'd0);
        chk("rst_cnt0",      32'(grant_cnt0), 32'd0);
        req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // ---- ADD on requester 0, L = 1 ----
        set_req0(32'd10, 32'd5, 3'b000, 7'b0000000);
        req0_valid = 1'b1;
        #1;
        chk("add_ready0", 32'(req0_ready), 32'd1);
        chk("add_ready1", 32'(req1_ready), 32'd0);
        tick();                                   // handshake edge
        req0_valid = 1'b0;
        chk("add_busy",      32'(busy),      32'd1);
        chk("add_no_rsp",    32'(rsp_valid), 32'd0);
        chk("add_eu_opA",    eu_opA,         32'd10);
        tick();                                   // E0+1
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_id",    32'(rsp_id),    32'd0);
        chk("add_rsp_data",  rsp_data,       32'd15);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("add_idle", 32'(busy), 32'd0);

        // ---- SUB on requester 1 ----
        set_req1(32'd10, 32'd5, 3'b000, 7'b0100000);
        req1_valid = 1'b1;
        #1;
        chk("sub_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("sub_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("sub_rsp_id",    32'(rsp_id),     32'd1);
        chk("sub_rsp_data",  rsp_data,        32'd5);
        chk("sub_cnt1",      32'(grant_cnt1), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- MUL on requester 0, L = MUL_LAT; rsp_ready high is ignored in EXEC ----
        set_req0(32'd8, 32'd3, 3'b000, 7'b0000001);
        req0_valid = 1'b1;
        tick();                                   // handshake edge
        req0_valid = 1'b0;
        req0_opA = 32'd99;                        // must not reach eu_opA
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mul_busy",    32'(busy),       32'd1);
            chk("mul_no_rsp",  32'(rsp_valid),  32'd0);
            chk("mul_eu_opA",  eu_opA,          32'd8);
            chk("mul_eu_aux",  32'(eu_auxFunc), 32'd1);
            tick();
        end
        chk("mul_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("mul_rsp_data",  rsp_data,        32'd24);
        chk("mul_cnt0",      32'(grant_cnt0), 32'd2);
        tick();                                   // consumed
        rsp_ready = 1'b0;

        // ---- SRA with a stalled consumer; req1 waits meanwhile ----
        set_req0(32'hFFFF_FFEC, 32'd1, 3'b101, 7'b0100000);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        set_req1(32'd1, 32'd1, 3'b000, 7'b0000000);
        req1_valid = 1'b1;
        tick();                                   // now in RESP
        for (int i = 0; i < 5; i++) begin
            chk("sra_rsp_valid", 32'(rsp_valid),  32'd1);
            chk("sra_rsp_data",  rsp_data,        32'hFFFF_FFF6);
            chk("sra_no_ready0", 32'(req0_ready), 32'd0);
            chk("sra_no_ready1", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("sra_idle",       32'(busy),       32'd0);
        chk("sra_rsp_done",   32'(rsp_valid),  32'd0);
        chk("sra_ready1_now", 32'(req1_ready), 32'd1);
        req1_valid = 1'b0;
        rsp_ready = 1'b0;

        // ---- reset in the 2nd cycle of a MUL EXEC ----
        set_req0(32'd7, 32'd6, 3'b000, 7'b0000001);
        req0_valid = 1'b1;
        tick();                                   // handshake edge
        req0_valid = 1'b0;
        tick();                                   // 2nd EXEC cycle
        chk("mrst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_busy",     32'(busy),       32'd0);
        chk("mrst_rsp",      32'(rsp_valid),  32'd0);
        chk("mrst_eu_opA",   eu_opA,          32'd0);
        chk("mrst_eu_aux",   32'(eu_auxFunc), 32'd0);
        chk("mrst_rsp_data", rsp_data,        32'd0);
        chk("mrst_cnt0",     32'(grant_cnt0), 32'd0);
        chk("mrst_cnt1",     32'(grant_cnt1), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // ---- contention after reset: SLL on both, alternating 0,1,0,1 ----
        set_req0(32'd8, 32'd2, 3'b001, 7'b0000000);
        set_req1(32'd8, 32'd2, 3'b001, 7'b0000000);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();                               // handshake
            tick();                               // result captured
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_id",    32'(rsp_id),    32'(i % 2));
            chk("rr_rsp_data",  rsp_data,       32'd32);
            tick();                               // consumed, back to IDLE
        end
        chk("rr_cnt0", 32'(grant_cnt0), 32'd2);
        chk("rr_cnt1", 32'(grant_cnt1), 32'd2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
